muldiv_unit: RTL

Parametrised multiply/divide unit with HI/LO registers, the sequential successor to alu_control. It decodes R-type funct codes (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) when aluOp_in indicates R-type, and runs iterative shift-add multiply or restoring divide over several cycles. It sits beside the ALU in the datapath and stalls the core while a long operation is in flight.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes, the
// R-type main-control ALU op, and the iteration FSM state encoding.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration bit of the multiply/divide datapath.
//   mode_in = 0 : shift-add multiply. {acc,q} holds {partial product, multiplier};
//                 add m when q[0] is set, then shift the pair right one bit.
//   mode_in = 1 : restoring divide. acc is the partial remainder, q shifts the
//                 dividend out at the top and quotient bits in at the bottom.
// Ports: mode_in (step kind), acc_in/q_in (state in), m_in (multiplicand or
//        divisor), acc_out/q_out (state after one bit).
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             mode_in,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic           fits;

   always_comb begin
      sum     = {1'b0, acc_in} + {1'b0, m_in};
      trial   = {acc_in, q_in[WIDTH-1]};
      fits    = (trial >= {1'b0, m_in});
      acc_out = acc_in;
      q_out   = q_in;
      if (!mode_in) begin
         if (q_in[0]) begin
            {acc_out, q_out} = {sum, q_in[WIDTH-1:1]};
         end else begin
            {acc_out, q_out} = {1'b0, acc_in, q_in[WIDTH-1:1]};
         end
      end else begin
         // When the subtraction fits, the true difference is below m and so
         // the low WIDTH bits of a modular subtract are exact.
         acc_out = fits ? (trial[WIDTH-1:0] - m_in) : trial[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], fits};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo when aluOp_in is R-type,
// runs WIDTH/STEPS_PER_CYCLE iteration cycles plus one sign fix-up cycle, and
// stalls any decoded op while busy.
// Ports: clk_in, reset_in (async, active-high), valid_in, aluOp_in, funct_in,
//        a_in (rs), b_in (rt); result_out (mfhi/mflo data), busy_out,
//        stall_out, done_out (result-written pulse), hi_out, lo_out.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             valid_in,
   input  logic [1:0]       aluOp_in,
   input  logic [5:0]       funct_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] result_out,
   output logic             busy_out,
   output logic             stall_out,
   output logic             done_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int N     = WIDTH / STEPS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d;
   logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, isdiv_q, isdiv_d;

   logic               dec, signed_op, a_neg, b_neg;
   logic               op_mul, op_div, op_mfhi, op_mflo, op_mthi, op_mtlo;
   logic [WIDTH-1:0]   a_mag, b_mag, step_acc, step_q, quo, rem;
   logic [2*WIDTH-1:0] prod;

   assign dec       = valid_in && (aluOp_in == ALUOP_RTYPE);
   assign op_mul    = dec && (funct_in == FUNCT_MULT || funct_in == FUNCT_MULTU);
   assign op_div    = dec && (funct_in == FUNCT_DIV  || funct_in == FUNCT_DIVU);
   assign op_mfhi   = dec && (funct_in == FUNCT_MFHI);
   assign op_mflo   = dec && (funct_in == FUNCT_MFLO);
   assign op_mthi   = dec && (funct_in == FUNCT_MTHI);
   assign op_mtlo   = dec && (funct_in == FUNCT_MTLO);
   // Signed variants (mult, div) have funct bit 0 clear.
   assign signed_op = ~funct_in[0];
   assign a_neg     = signed_op && a_in[WIDTH-1];
   assign b_neg     = signed_op && b_in[WIDTH-1];
   assign a_mag     = mag(a_in, a_neg);
   assign b_mag     = mag(b_in, b_neg);

   assign busy_out  = (state_q != IDLE);
   assign stall_out = busy_out && (op_mul || op_div || op_mfhi || op_mflo || op_mthi || op_mtlo);
   assign done_out  = done_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

   always_comb begin
      result_out = '0;
      if (!busy_out) begin
         if (op_mfhi) result_out = hi_q;
         else if (op_mflo) result_out = lo_q;
      end
   end

   // Iteration chain: STEPS_PER_CYCLE single-bit steps per clock.
   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      logic [WIDTH-1:0] acc_i, q_i, acc_o, q_o;
      if (i == 0) begin : g_first
         assign acc_i = acc_q;
         assign q_i   = q_q;
      end else begin : g_next
         assign acc_i = g_step[i-1].acc_o;
         assign q_i   = g_step[i-1].q_o;
      end
      muldiv_step #(.WIDTH(WIDTH)) u_step (
         .mode_in (state_q == DIV),
         .acc_in  (acc_i),
         .q_in    (q_i),
         .m_in    (m_q),
         .acc_out (acc_o),
         .q_out   (q_o)
      );
   end
   assign step_acc = g_step[STEPS_PER_CYCLE-1].acc_o;
   assign step_q   = g_step[STEPS_PER_CYCLE-1].q_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      acc_d   = acc_q;
      q_d     = q_q;
      m_d     = m_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      isdiv_d = isdiv_q;
      prod    = {acc_q, q_q};
      quo     = q_q;
      rem     = acc_q;
      case (state_q)
         IDLE: begin
            if (op_mul || op_div) begin
               acc_d   = '0;
               cnt_d   = CNT_W'(N);
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               dz_d    = (b_in == '0);
               isdiv_d = op_div;
               if (op_div) begin
                  q_d     = a_mag;
                  m_d     = b_mag;
                  state_d = DIV;
               end else begin
                  q_d     = b_mag;
                  m_d     = a_mag;
                  state_d = MUL;
               end
            end else if (op_mthi) begin
               hi_d = a_in;
            end else if (op_mtlo) begin
               lo_d = a_in;
            end
         end
         MUL, DIV: begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            if (isdiv_q) begin
               // Divide by zero leaves |a| as remainder; restoring the dividend
               // sign yields a_in exactly, so only LO needs overriding.
               quo  = neg_q ? -q_q : q_q;
               rem  = rneg_q ? -acc_q : acc_q;
               hi_d = rem;
               lo_d = dz_q ? '1 : quo;
            end else begin
               prod         = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Operand/iteration datapath: only consumed after a fresh latch in IDLE.
   always_ff @(posedge clk_in) begin
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      isdiv_q <= isdiv_d;
   end

endmodule
